// File: rtl/uart_rx_control.sv
// ---------------------------------------------------------------------------
// uart_rx_control
//
// Receive-side control stage of the UART. The raw serial line is resynchronised
// and watched for a start-bit falling edge. On that edge the stage enables the
// external baud counter (count_sig) and samples the start, data, optional
// parity and stop bits on the counter's mid-bit pulses (bps_clk). A clean frame
// updates rx_data and pulses rx_done_sig for one cycle. These two outputs feed
// the TX stage's tx_data / rx_done_sig inputs directly (echo path).
//
// Optional feature: define UART_RX_PARITY_EN to add a parity bit between the
// last data bit and the stop bit. PARITY_ODD selects the sense (0 even, 1 odd).
// Without the macro the frame is start + DATA_W data + stop, and parity_err is
// tied low.
//
// Parameters:
//   DATA_W      data bits per frame, LSB first, 5..8
//   PARITY_ODD  parity sense when UART_RX_PARITY_EN is defined
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   rx_pin_in    in   raw serial line, idle high, asynchronous to clk
//   bps_clk      in   one-clk mid-bit sample pulse, valid while count_sig=1
//   count_sig    out  baud counter enable, start edge .. stop-bit sample
//   rx_data      out  last correctly received byte
//   rx_done_sig  out  one-cycle pulse: rx_data just updated
//   frame_err    out  one-cycle pulse: stop bit sampled low
//   parity_err   out  one-cycle pulse: parity mismatch (0 without parity)
// ---------------------------------------------------------------------------
module uart_rx_control #(
    parameter int DATA_W     = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_pin_in,
    input  logic              bps_clk,
    output logic              count_sig,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_done_sig,
    output logic              frame_err,
    output logic              parity_err
);

    // Elaboration-time guard on the parameter ranges.
    if (DATA_W < 5 || DATA_W > 8 || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
        $error("uart_rx_control: DATA_W must be 5..8 and PARITY_ODD 0 or 1");
    end

    localparam int                IDX_W    = $clog2(DATA_W);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PAR,
`endif
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              prev_q, prev_d;
    logic              count_q, count_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              ferr_q, ferr_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic rx_s;
    logic h2l;

    assign rx_s = sync2_q;
    // prev_q is rx_s one clk late, so a 1->0 step on the synchronised line
    // shows up here for exactly one cycle.
    assign h2l  = prev_q & ~rx_s;

`ifdef UART_RX_PARITY_EN
    localparam logic ODD = (PARITY_ODD != 0);

    logic par_mis_q, par_mis_d;
    logic perr_q, perr_d;
    logic exp_par;

    // Parity bit that makes the total count of ones even (or odd).
    assign exp_par = (^shift_q) ^ ODD;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch instead of a mux.
        state_d = state_q;
        sync1_d = rx_pin_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        count_d = count_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        shift_d = shift_q;
        idx_d   = idx_q;
`ifdef UART_RX_PARITY_EN
        par_mis_d = par_mis_q;
        perr_d    = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                // bps_clk is ignored here; only a start edge moves us on.
                if (h2l) begin
                    state_d = START;
                    count_d = 1'b1;
                end
            end

            START: begin
                if (bps_clk) begin
                    if (!rx_s) begin
                        state_d = DATA;
                        idx_d   = '0;
`ifdef UART_RX_PARITY_EN
                        par_mis_d = 1'b0;
`endif
                    end else begin
                        // Glitch, not a start bit: drop back quietly.
                        state_d = IDLE;
                        count_d = 1'b0;
                    end
                end
            end

            DATA: begin
                if (bps_clk) begin
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PAR;
`else
                        state_d = STOP;
`endif
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PAR: begin
                if (bps_clk) begin
                    par_mis_d = (rx_s != exp_par);
                    state_d   = STOP;
                end
            end
`endif

            STOP: begin
                if (bps_clk) begin
                    // Counter is released on the same edge that registers the
                    // result pulses, so it is already low while they are high.
                    state_d = IDLE;
                    count_d = 1'b0;
                    ferr_d  = ~rx_s;
`ifdef UART_RX_PARITY_EN
                    perr_d  = par_mis_q;
                    if (rx_s && !par_mis_q) begin
`else
                    if (rx_s) begin
`endif
                        data_d = shift_q;
                        done_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                count_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before this edge regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            count_q <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            // NOTE: the shift register is a plain register, not a memory, so
            // it is reset like the rest; a mid-frame reset discards the byte.
            shift_q <= '0;
            idx_q   <= '0;
`ifdef UART_RX_PARITY_EN
            par_mis_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            count_q <= count_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
`ifdef UART_RX_PARITY_EN
            par_mis_q <= par_mis_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign count_sig   = count_q;
    assign rx_data     = data_q;
    assign rx_done_sig = done_q;
    assign frame_err   = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = perr_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_control.sv
`timescale 1ns/1ps
module tb_uart_rx_control;

    localparam int   DATA_W   = 8;
    localparam int   BIT_CLKS = 16;
    localparam logic PODD     = 1'b0;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rx_pin_in;
    logic              bps_clk;
    logic              count_sig;
    logic [DATA_W-1:0] rx_data;
    logic              rx_done_sig;
    logic              frame_err;
    logic              parity_err;

    uart_rx_control #(.DATA_W(DATA_W), .PARITY_ODD(0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_pin_in   (rx_pin_in),
        .bps_clk     (bps_clk),
        .count_sig   (count_sig),
        .rx_data     (rx_data),
        .rx_done_sig (rx_done_sig),
        .frame_err   (frame_err),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       done;
        logic       ferr;
        logic       perr;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       par_ok;
        logic       stop_bit;
    } vec_t;

    exp_t       sb[$];
    vec_t       vecs[$];
    int         tests_run = 0;
    int         fails     = 0;
    logic [7:0] last_good = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Baud counter model: first pulse 8 clk after count_sig rises, then every 16.
    int bcnt = 0;
    always @(negedge clk) begin
        if (!rst_n || !count_sig) begin
            bcnt    = 0;
            bps_clk = 1'b0;
        end else begin
            bcnt++;
            bps_clk = (bcnt == 8) || (bcnt > 8 && ((bcnt - 8) % BIT_CLKS) == 0);
        end
    end

    // Scoreboard monitor: every result pulse pops one expected record.
    always @(negedge clk) begin
        if (rst_n && (rx_done_sig || frame_err || parity_err)) begin
            if (sb.size() == 0) begin
                check("unexpected_event", {29'd0, rx_done_sig, frame_err, parity_err}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done",      rx_done_sig, e.done);
                check("frame_err", frame_err,   e.ferr);
                check("parity_err", parity_err, e.perr);
                check("rx_data",   rx_data,     e.data);
                check("count_low_at_result", count_sig, 1'b0);
            end
        end
    end

    task automatic push_expect(input logic [7:0] d, input logic par_ok, input logic stop_bit);
        exp_t e;
`ifdef UART_RX_PARITY_EN
        e.perr = ~par_ok;
        e.done = stop_bit & par_ok;
`else
        e.perr = 1'b0;
        e.done = stop_bit;
`endif
        e.ferr = ~stop_bit;
        if (e.done) last_good = d;
        e.data = last_good;
        sb.push_back(e);
    endtask

    task automatic drive_bit(input logic b);
        rx_pin_in = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_ok, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < DATA_W; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ PODD ^ ~par_ok);
`endif
        drive_bit(stop_bit);
        rx_pin_in = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || count_sig) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("sb_drained", sb.size(), 0);
        check("count_idle", count_sig, 1'b0);
        sb.delete();
        repeat (20) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_count"},  count_sig,   1'b0);
        check({tag, "_data"},   rx_data,     8'h00);
        check({tag, "_done"},   rx_done_sig, 1'b0);
        check({tag, "_ferr"},   frame_err,   1'b0);
        check({tag, "_perr"},   parity_err,  1'b0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] partial;
        int         n;

        vecs.push_back('{8'h3C, 1'b1, 1'b1});  // good frame
        vecs.push_back('{8'hA5, 1'b1, 1'b1});  // good frame
        vecs.push_back('{8'h3C, 1'b1, 1'b0});  // bad stop, data stays A5
        vecs.push_back('{8'h01, 1'b1, 1'b1});
        vecs.push_back('{8'h80, 1'b1, 1'b1});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h07, 1'b1, 1'b1});  // parity bit 1: good
        vecs.push_back('{8'h07, 1'b0, 1'b1});  // parity bit 0: parity_err
        vecs.push_back('{8'h07, 1'b0, 1'b0});  // both errors together
`endif

        rst_n     = 1'b0;
        rx_pin_in = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // False start: 4 clk low pulse, gone before the first sample.
        rx_pin_in = 1'b0;
        repeat (4) @(negedge clk);
        rx_pin_in = 1'b1;
        n = 0;
        while (!count_sig && n < 10) begin @(negedge clk); n++; end
        check("false_start_count_rise", count_sig, 1'b1);
        n = 0;
        while (count_sig && n < 40) begin @(negedge clk); n++; end
        check("false_start_count_fall", count_sig, 1'b0);
        repeat (20) @(negedge clk);

        // Table of single frames.
        for (int i = 0; i < vecs.size(); i++) begin
            push_expect(vecs[i].data, vecs[i].par_ok, vecs[i].stop_bit);
            send_frame(vecs[i].data, vecs[i].par_ok, vecs[i].stop_bit);
            wait_idle();
        end

        // Back-to-back frames, no idle gap after the stop bit.
        push_expect(8'h00, 1'b1, 1'b1);
        push_expect(8'hFF, 1'b1, 1'b1);
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        wait_idle();

        // Break: line held low through the stop bit and beyond.
        push_expect(8'h00, 1'b1, 1'b0);
        send_frame(8'h00, 1'b1, 1'b0);
        rx_pin_in = 1'b0;
        repeat (64) @(negedge clk);
        check("break_no_restart", count_sig, 1'b0);
        check("break_sb_drained", sb.size(), 0);
        rx_pin_in = 1'b1;
        wait_idle();
        push_expect(8'h96, 1'b1, 1'b1);
        send_frame(8'h96, 1'b1, 1'b1);
        wait_idle();

        // Reset mid-frame after 4 data bits of 0x81.
        partial = 8'h81;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(partial[i]);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        last_good = 8'h00;
        rx_pin_in = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        push_expect(8'h5A, 1'b1, 1'b1);
        send_frame(8'h5A, 1'b1, 1'b1);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
